mux_y_deserializer: RTL
=======================

// Module: mux_y_deserializer
// PURPOSE
//   Downstream capture stage for the Logic_mux2 output y. Samples y on enabled
//   clock cycles, assembles WIDTH samples LSB-first into a word, and presents it
//   through a single-entry valid/ready holding register. Also counts y
//   transitions and flags dropped words. Lets the bench and the Python checker
//   read mux results as words instead of probing y bit by bit.
// PARAMETERS
//   WIDTH  8   samples per assembled word (>=2)
//   CNT_W  16  width of the saturating transition counter
// PORTS
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   y_in        in   1      mux output y, same clock domain, no synchronizer
//   sample_en   in   1      sample y_in this cycle
//   clear       in   1      synchronous flush of all state
//   word_data   out  WIDTH  assembled word, first sample in bit 0
//   word_valid  out  1      word_data holds an unconsumed word
//   word_ready  in   1      consumer accepts word this cycle
//   overrun     out  1      sticky: a completed word was dropped
//   edge_count  out  CNT_W  number of y transitions between sampled values
// BEHAVIOUR
//   Reset (rst_n=0, async): shift reg, bit count, word_data, word_valid,
//     overrun, edge_count, prev_y, prev_vld all 0. Holding FSM = EMPTY.
//   Priority per cycle: rst_n > clear > normal operation.
//   clear=1: same state as reset, applied on the clock edge; a held word is
//     discarded; sample_en ignored that cycle.
//   Assembly: on sample_en=1, shift <= {y_in, shift[WIDTH-1:1]}, bit count +1.
//     The sample that brings the count to WIDTH completes the word; count wraps
//     to 0. sample_en=0 freezes shift reg and count (gaps allowed).
//   Holding FSM (EMPTY/FULL); word_valid = (state==FULL):
//     EMPTY + completion        -> FULL, word_data <= completed word. Latency:
//       word_valid is 1 in the cycle after the edge that took the last sample.
//     FULL + ready, no complete -> EMPTY.
//     FULL + ready + completion -> stay FULL, word_data <= new word, no overrun.
//     FULL + !ready + completion -> stay FULL, word_data unchanged, new word
//       dropped, overrun <= 1.
//   word_data must not change while word_valid=1 and word_ready=0.
//   word_ready while EMPTY has no effect.
//   overrun is sticky until clear or reset.
//   Edge count: on sample_en=1 with prev_vld=1 and y_in != prev_y, increment
//     edge_count; saturates at 2**CNT_W-1 (no wrap). Then prev_y <= y_in,
//     prev_vld <= 1. The first sample after reset/clear never counts.
//   Reset mid-word: partial bits lost, next word starts from bit 0.
// TESTING
//   1 Reset: 3 samples, then rst_n=0 mid-cycle -> all outputs 0 at once; next
//     8 samples form a fresh word with no stale bits.
//   2 Basic: ready=1, y=1,0,1,1,0,0,1,0 on 8 enabled cycles -> word_data=8'h4D,
//     word_valid high one cycle after 8th sample, edge_count=5, overrun=0.
//   3 Backpressure: ready=0, 16 samples (8'hFF then 8'h00) -> word_data stays
//     8'hFF, overrun=1; raise ready -> valid drops next cycle; clear -> overrun=0.
//   4 Simultaneous: word A held, ready=1 in the cycle word B completes ->
//     word_valid stays 1, word_data=B, overrun=0.
//   5 Gaps: basic pattern with sample_en=0 between every sample -> same 8'h4D,
//     same edge_count=5; valid only after 8th enabled sample.
//   6 Saturation: CNT_W=4, 20 alternating samples -> edge_count=15, holds at 15.

Source files
------------

// File: rtl/mux_y_if.sv
// mux_y_if: capture-stage bus between the y sampler and its word consumer
interface mux_y_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             y_in;
    logic             sample_en;
    logic             clear;
    logic             word_ready;
    logic [WIDTH-1:0] word_data;
    logic             word_valid;
    logic             overrun;
    logic [CNT_W-1:0] edge_count;
    modport master (
        output y_in, sample_en, clear, word_ready,
        input  word_data, word_valid, overrun, edge_count
    );
    modport slave (
        input  y_in, sample_en, clear, word_ready,
        output word_data, word_valid, overrun, edge_count
    );
endinterface

// File: rtl/mux_y_deserializer.sv
// mux_y_deserializer: samples mux y LSB-first into words behind a one-entry valid/ready holder
module mux_y_deserializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic   clk,
    input logic   rst_n,
    mux_y_if.slave bus
);
    localparam int BW = $clog2(WIDTH);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d, data_q, data_d, new_word;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] edge_q, edge_d;
    logic             ovr_q, ovr_d, prev_y_q, prev_y_d, prev_vld_q, prev_vld_d;
    logic             complete;
    always_comb begin
        new_word   = {bus.y_in, shift_q[WIDTH-1:1]};
        complete   = bus.sample_en && (cnt_q == BW'(WIDTH - 1));
        shift_d    = bus.sample_en ? new_word : shift_q;
        cnt_d      = bus.sample_en ? (complete ? '0 : cnt_q + 1'b1) : cnt_q;
        prev_y_d   = bus.sample_en ? bus.y_in : prev_y_q;
        prev_vld_d = prev_vld_q | bus.sample_en;
        edge_d     = (bus.sample_en && prev_vld_q && bus.y_in != prev_y_q && edge_q != '1)
                     ? edge_q + 1'b1 : edge_q;
        state_d    = state_q;
        data_d     = data_q;
        ovr_d      = ovr_q;
        if (state_q == EMPTY) begin
            state_d = complete ? FULL : EMPTY;
            data_d  = complete ? new_word : data_q;
        end else if (complete) begin
            // a full holder only takes the new word if the old one leaves this cycle
            data_d = bus.word_ready ? new_word : data_q;
            ovr_d  = ovr_q | !bus.word_ready;
        end else begin
            state_d = bus.word_ready ? EMPTY : FULL;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            shift_q    <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            ovr_q      <= 1'b0;
            edge_q     <= '0;
            prev_y_q   <= 1'b0;
            prev_vld_q <= 1'b0;
        end else if (bus.clear) begin
            state_q    <= EMPTY;
            shift_q    <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            ovr_q      <= 1'b0;
            edge_q     <= '0;
            prev_y_q   <= 1'b0;
            prev_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            ovr_q      <= ovr_d;
            edge_q     <= edge_d;
            prev_y_q   <= prev_y_d;
            prev_vld_q <= prev_vld_d;
        end
    end
    assign bus.word_data  = data_q;
    assign bus.word_valid = (state_q == FULL);
    assign bus.overrun    = ovr_q;
    assign bus.edge_count = edge_q;
endmodule
